// File: rtl/mimo_issue_fifo_pkg.sv
// Shared helpers for the multi-lane issue FIFO: lane-prefix counting and
// pointer/counter width derivation from the configured depth.
package fifo_pkg;

    localparam int unsigned MAX_LANES = 32;

    typedef logic [MAX_LANES-1:0] lane_vec_t;

    // Counts the contiguous run of ones starting at bit 0; stops at the first zero.
    function automatic int unsigned lead_ones(input lane_vec_t vec);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            run = run & vec[i];
            if (run) begin
                n++;
            end
        end
        return n;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mimo_issue_fifo.sv
// In-order multi-in/multi-out instruction buffer between decode and issue.
// Circular store addressed by power-of-two wrapping pointers; outputs are register-driven.
module mimo_issue_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WPORT      = 2,
    parameter int unsigned RPORT      = 2,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic [WPORT-1:0]             write_valid_i,
    output logic [$clog2(WPORT+1)-1:0]   write_num_o,
    input  dtype                         write_data_i [WPORT],
    output logic [RPORT-1:0]             read_valid_o,
    input  logic [RPORT-1:0]             issue_i,
    output dtype                         read_data_o [RPORT],
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned WN_W  = $clog2(WPORT + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [WN_W-1:0]  wnum_t;

    dtype        mem_q [DEPTH];
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        free_cnt;
    cnt_t        pop_num;
    wnum_t       write_num;
    int unsigned wr_accept;
    int unsigned rd_lead;

    // Free space comes from registered occupancy only, so issue_i never reaches write_num_o.
    assign free_cnt = cnt_t'(DEPTH) - count_q;

    always_comb begin
        wr_accept = lead_ones(lane_vec_t'(write_valid_i));
        if (wr_accept > 32'(free_cnt)) begin
            wr_accept = 32'(free_cnt);
        end
        write_num = flush_i ? '0 : wnum_t'(wr_accept);
    end

    always_comb begin
        rd_lead = lead_ones(lane_vec_t'(issue_i & read_valid_o));
        pop_num = cnt_t'(rd_lead);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + ptr_t'(write_num);
            rd_ptr_d = rd_ptr_q + ptr_t'(pop_num);
            count_d  = count_q + cnt_t'(write_num) - pop_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload store is deliberately not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(WPORT); k++) begin
            if (k < int'(write_num)) begin
                mem_q[wr_ptr_q + ptr_t'(k)] <= write_data_i[k];
            end
        end
    end

    for (genvar gi = 0; gi < int'(RPORT); gi++) begin : g_read_lane
        assign read_valid_o[gi] = (count_q > cnt_t'(gi));
        assign read_data_o[gi]  = mem_q[rd_ptr_q + ptr_t'(gi)];
    end

    assign write_num_o = write_num;
    assign count_o     = count_q;

`ifndef SYNTHESIS
    a_write_valid_therm : assert property (@(posedge clk) disable iff (!rst_n)
        ((write_valid_i & (write_valid_i + WPORT'(1))) == '0));
    a_issue_therm : assert property (@(posedge clk) disable iff (!rst_n)
        ((issue_i & (issue_i + RPORT'(1))) == '0));
    a_issue_subset : assert property (@(posedge clk) disable iff (!rst_n)
        ((issue_i & ~read_valid_o) == '0));
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        (count_q <= cnt_t'(DEPTH)));
`endif

endmodule

// File: tb/tb_mimo_issue_fifo.sv
// Scoreboard bench for mimo_issue_fifo: runs the same scenarios on a
// DEPTH=8/W2/R2 instance and a DEPTH=16/W4/R2 instance.
module tb_mimo_issue_fifo;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          flush;
    logic [3:0]    wv;
    logic [DW-1:0] wd [4];
    logic [1:0]    iss;
    int            cfg;

    logic [1:0]    wv0, iss0, wn0, rv0;
    logic [DW-1:0] wd0 [2];
    logic [DW-1:0] rd0 [2];
    logic [3:0]    cnt0;
    logic [3:0]    wv1;
    logic [1:0]    iss1, rv1;
    logic [2:0]    wn1;
    logic [DW-1:0] wd1 [4];
    logic [DW-1:0] rd1 [2];
    logic [4:0]    cnt1;

    // Only the selected instance sees traffic; the other idles.
    assign wv0    = (cfg == 0) ? wv[1:0] : 2'b00;
    assign iss0   = (cfg == 0) ? iss : 2'b00;
    assign wv1    = (cfg == 1) ? wv : 4'b0000;
    assign iss1   = (cfg == 1) ? iss : 2'b00;
    assign wd0[0] = wd[0];
    assign wd0[1] = wd[1];
    assign wd1[0] = wd[0];
    assign wd1[1] = wd[1];
    assign wd1[2] = wd[2];
    assign wd1[3] = wd[3];

    mimo_issue_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .WPORT(2), .RPORT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .write_valid_i(wv0), .write_num_o(wn0), .write_data_i(wd0),
        .read_valid_o(rv0), .issue_i(iss0), .read_data_o(rd0), .count_o(cnt0)
    );

    mimo_issue_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .WPORT(4), .RPORT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .write_valid_i(wv1), .write_num_o(wn1), .write_data_i(wd1),
        .read_valid_o(rv1), .issue_i(iss1), .read_data_o(rd1), .count_o(cnt1)
    );

    logic [2:0]    wn_o;
    logic [1:0]    rv_o;
    logic [DW-1:0] rd_o [2];
    logic [4:0]    cnt_o;
    logic [DW-1:0] mem0_o;

    always_comb begin
        if (cfg == 0) begin
            wn_o    = {1'b0, wn0};
            rv_o    = rv0;
            rd_o[0] = rd0[0];
            rd_o[1] = rd0[1];
            cnt_o   = {1'b0, cnt0};
            mem0_o  = dut0.mem_q[0];
        end else begin
            wn_o    = wn1;
            rv_o    = rv1;
            rd_o[0] = rd1[0];
            rd_o[1] = rd1[1];
            cnt_o   = cnt1;
            mem0_o  = dut1.mem_q[0];
        end
    end

    // Reference model state
    logic [DW-1:0] sb [$];
    int            m_cnt;
    int            depth;
    int            wport;
    int            next_val;
    int            n_checks;
    int            n_pass;

    function automatic int lead(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && n == i) n++;
        end
        return n;
    endfunction

    function automatic logic [1:0] exp_valid();
        logic [1:0] v;
        v[0] = (m_cnt > 0);
        v[1] = (m_cnt > 1);
        return v;
    endfunction

    function automatic int exp_wn();
        logic [3:0] v;
        int         n;
        v = (cfg == 0) ? {2'b00, wv[1:0]} : wv;
        n = lead(v);
        if (n > depth - m_cnt) n = depth - m_cnt;
        if (flush) n = 0;
        return n;
    endfunction

    function automatic int exp_pop();
        return lead({2'b00, iss & exp_valid()});
    endfunction

    function automatic logic [DW-1:0] nv();
        next_val++;
        return 32'((cfg + 1) * 32'h0100_0000 + next_val);
    endfunction

    task automatic idle();
        wv    = 4'b0000;
        iss   = 2'b00;
        flush = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        m_cnt = 0;
    endtask

    // Advances one active edge and applies the same edge to the model.
    task automatic tick();
        int wn;
        int pop;
        wn  = exp_wn();
        pop = exp_pop();
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            repeat (pop) void'(sb.pop_front());
            for (int k = 0; k < wn; k++) sb.push_back(wd[k]);
            m_cnt = m_cnt + wn - pop;
        end
        #1;
    endtask

    task automatic fill_to(input int target);
        int n;
        while (m_cnt < target) begin
            n = target - m_cnt;
            if (n > wport) n = wport;
            wv = 4'((1 << n) - 1);
            for (int k = 0; k < 4; k++) wd[k] = nv();
            tick();
        end
        wv = 4'b0000;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (rv_o !== 2'b00) $display("FAIL cfg%0d reset_valid: got %b expected 00", cfg, rv_o);
        else n_pass++;
        n_checks++;
        if (cnt_o !== 5'd0) $display("FAIL cfg%0d reset_count: got %0d expected 0", cfg, cnt_o);
        else n_pass++;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] a, b;
        a     = nv();
        b     = nv();
        wd[0] = a;
        wd[1] = b;
        wv    = 4'b0011;
        @(negedge clk);
        n_checks++;
        if (wn_o !== 3'd2) $display("FAIL cfg%0d basic_wnum: got %0d expected 2", cfg, wn_o);
        else n_pass++;
        tick();
        wv = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (rv_o !== 2'b11) $display("FAIL cfg%0d basic_valid: got %b expected 11", cfg, rv_o);
        else n_pass++;
        n_checks++;
        if (rd_o[0] !== a || rd_o[1] !== b)
            $display("FAIL cfg%0d basic_data: got %h,%h expected %h,%h", cfg, rd_o[0], rd_o[1], a, b);
        else n_pass++;
        n_checks++;
        if (cnt_o !== 5'd2) $display("FAIL cfg%0d basic_count: got %0d expected 2", cfg, cnt_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_fill();
        test_reset();
        fill_to(depth - 1);
        wv = 4'b0011;
        for (int k = 0; k < 4; k++) wd[k] = nv();
        @(negedge clk);
        n_checks++;
        if (wn_o !== 3'd1) $display("FAIL cfg%0d fill_last_wnum: got %0d expected 1", cfg, wn_o);
        else n_pass++;
        tick();
        wv = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (cnt_o !== 5'(depth)) $display("FAIL cfg%0d fill_count: got %0d expected %0d", cfg, cnt_o, depth);
        else n_pass++;
        n_checks++;
        if (wn_o !== 3'd0) $display("FAIL cfg%0d full_wnum: got %0d expected 0", cfg, wn_o);
        else n_pass++;
        tick();
        wv = 4'b0000;
    endtask

    task automatic test_full_issue();
        iss = 2'b11;
        wv  = 4'b0011;
        for (int k = 0; k < 4; k++) wd[k] = nv();
        @(negedge clk);
        n_checks++;
        if (wn_o !== 3'd0) $display("FAIL cfg%0d full_issue_wnum: got %0d expected 0", cfg, wn_o);
        else n_pass++;
        n_checks++;
        if (rd_o[0] !== sb[0] || rd_o[1] !== sb[1])
            $display("FAIL cfg%0d full_issue_data: got %h,%h expected %h,%h", cfg, rd_o[0], rd_o[1], sb[0], sb[1]);
        else n_pass++;
        tick();
        iss = 2'b00;
        @(negedge clk);
        n_checks++;
        if (cnt_o !== 5'(depth - 2)) $display("FAIL cfg%0d full_issue_count: got %0d expected %0d", cfg, cnt_o, depth - 2);
        else n_pass++;
        n_checks++;
        if (wn_o !== 3'd2) $display("FAIL cfg%0d freed_wnum: got %0d expected 2", cfg, wn_o);
        else n_pass++;
        tick();
        wv = 4'b0000;
    endtask

    task automatic test_stream();
        int written;
        int cycles;
        int goal;
        int r;
        int pop;
        test_reset();
        written = 0;
        cycles  = 0;
        goal    = 2 * depth + 4;
        while ((written < goal || m_cnt > 0) && cycles < 400) begin
            if (written < goal) begin
                r  = int'($urandom_range(0, wport));
                wv = 4'((1 << r) - 1);
                for (int k = 0; k < 4; k++) wd[k] = nv();
            end else begin
                wv = 4'b0000;
            end
            r   = int'($urandom_range(0, 2));
            iss = 2'((1 << r) - 1) & exp_valid();
            @(negedge clk);
            n_checks++;
            if (wn_o !== 3'(exp_wn())) $display("FAIL cfg%0d stream_wnum: got %0d expected %0d", cfg, wn_o, exp_wn());
            else n_pass++;
            n_checks++;
            if (cnt_o !== 5'(m_cnt)) $display("FAIL cfg%0d stream_count: got %0d expected %0d", cfg, cnt_o, m_cnt);
            else n_pass++;
            pop = exp_pop();
            for (int i = 0; i < pop; i++) begin
                n_checks++;
                if (rd_o[i] !== sb[i]) $display("FAIL cfg%0d stream_issue%0d: got %h expected %h", cfg, i, rd_o[i], sb[i]);
                else n_pass++;
            end
            written += exp_wn();
            tick();
            cycles++;
        end
        idle();
        n_checks++;
        if (cycles >= 400) $display("FAIL cfg%0d stream_timeout: got %0d cycles expected under 400", cfg, cycles);
        else n_pass++;
        n_checks++;
        if (cnt_o !== 5'd0) $display("FAIL cfg%0d stream_drained: got %0d expected 0", cfg, cnt_o);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [DW-1:0] x;
        test_reset();
        fill_to(5);
        wv    = 4'b0011;
        iss   = 2'b11;
        flush = 1'b1;
        for (int k = 0; k < 4; k++) wd[k] = nv();
        @(negedge clk);
        n_checks++;
        if (wn_o !== 3'd0) $display("FAIL cfg%0d flush_wnum: got %0d expected 0", cfg, wn_o);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (rv_o !== 2'b00 || cnt_o !== 5'd0)
            $display("FAIL cfg%0d flush_empty: got valid=%b count=%0d expected valid=00 count=0", cfg, rv_o, cnt_o);
        else n_pass++;
        x     = nv();
        wd[0] = x;
        wv    = 4'b0001;
        tick();
        wv = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (rd_o[0] !== x || rv_o !== 2'b01 || cnt_o !== 5'd1)
            $display("FAIL cfg%0d post_flush_write: got %h valid=%b count=%0d expected %h valid=01 count=1",
                     cfg, rd_o[0], rv_o, cnt_o, x);
        else n_pass++;
        n_checks++;
        if (mem0_o !== x) $display("FAIL cfg%0d post_flush_index0: got %h expected %h", cfg, mem0_o, x);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        test_reset();
        fill_to(4);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rv_o !== 2'b00 || cnt_o !== 5'd0)
            $display("FAIL cfg%0d async_reset: got valid=%b count=%0d expected valid=00 count=0", cfg, rv_o, cnt_o);
        else n_pass++;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        cfg      = 0;
        next_val = 0;
        n_checks = 0;
        n_pass   = 0;
        m_cnt    = 0;
        idle();
        for (int k = 0; k < 4; k++) wd[k] = '0;
        for (int c = 0; c < 2; c++) begin
            cfg   = c;
            depth = (c == 0) ? 8 : 16;
            wport = (c == 0) ? 2 : 4;
            test_reset();
            test_basic();
            test_fill();
            test_full_issue();
            test_stream();
            test_flush();
            test_async_reset();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
